// File: rtl/apb_slave_regfile.sv
// APB completer with NUM_REGS word registers, WAIT_CYCLES wait states and pslverr on bad addresses.
// Latency: pready at setup+1+WAIT_CYCLES; no backpressure beyond wait states; psel drop aborts.
module apb_slave_regfile #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [IW:0] NREG = NUM_REGS[IW:0];
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            err_q, err_d;
  logic            wr_q, wr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic            pready_q, pready_d;
  logic            pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic            setup;
  logic            setup_err;
  logic [IW-1:0]   cur_idx;
  logic            cur_err;
  logic            cur_wr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] load_data;

  assign setup     = psel && !penable;
  assign setup_err = (paddr[1:0] != 2'b00) || ({1'b0, paddr[ADDR_WIDTH-1:2]} >= NREG);

  // With zero wait states DONE is entered straight from the setup cycle, so read the live decode.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_idx = paddr[ADDR_WIDTH-1:2];
      cur_err = setup_err;
      cur_wr  = pwrite;
    end else begin
      cur_idx = idx_q;
      cur_err = err_q;
      cur_wr  = wr_q;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cur_idx == i[IW-1:0]) begin
        rd_word = regs_q[i];
      end
    end
  end

  assign load_data = (cur_err || cur_wr) ? '0 : rd_word;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    wr_d      = wr_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    regs_d    = regs_q;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          idx_d = paddr[ADDR_WIDTH-1:2];
          err_d = setup_err;
          wr_d  = pwrite;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d   = S_DONE;
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            prdata_d  = load_data;
          end
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d   = S_DONE;
          pready_d  = 1'b1;
          pslverr_d = err_q;
          prdata_d  = load_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (psel && penable && wr_q && !err_q) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == i[IW-1:0]) begin
              regs_d[i] = pwdata;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      regs_q    <= regs_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (0, 1, 3 wait states) against an array model.
module tb_apb_slave_regfile;

  logic        clk;
  logic        rstn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata_w [3];
  logic [2:0]  pready_w;
  logic [2:0]  pslverr_w;

  int total = 0;
  int bad   = 0;
  int wc [3] = '{0, 1, 3};
  logic [31:0] mregs [3][16];

  apb_slave_regfile #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .rstn(rstn), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_w[0]), .pready(pready_w[0]),
    .pslverr(pslverr_w[0]));
  apb_slave_regfile #(.WAIT_CYCLES(1)) u1 (
    .clk(clk), .rstn(rstn), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_w[1]), .pready(pready_w[1]),
    .pslverr(pslverr_w[1]));
  apb_slave_regfile #(.WAIT_CYCLES(3)) u2 (
    .clk(clk), .rstn(rstn), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_w[2]), .pready(pready_w[2]),
    .pslverr(pslverr_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          d;
    bit          wr;
    logic [11:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    bit          ee;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the completion edge.
  task automatic xfer(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic se, output int waits);
    psel    = 3'b000;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    tick(1);
    penable = 1'b1;
    waits = 0;
    while (pready_w[d] !== 1'b1 && waits < 40) begin
      tick(1);
      waits++;
    end
    rd = prdata_w[d];
    se = pslverr_w[d];
    tick(1);
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  function automatic bit addr_err(input logic [11:0] a);
    return (a[1:0] != 2'b00) || (a[11:2] >= 10'd16);
  endfunction

  task automatic do_op(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] rd;
    logic        se;
    int          waits;
    bit          e;
    logic [31:0] exp;
    e   = addr_err(a);
    exp = e ? 32'h0 : mregs[d][a[5:2]];
    xfer(d, wr, a, wd, rd, se, waits);
    chk($sformatf("waits d%0d", d), 32'(waits), 32'(wc[d]));
    chk($sformatf("pslverr d%0d a=%h", d, a), {31'b0, se}, {31'b0, e});
    if (!wr) chk($sformatf("prdata d%0d a=%h", d, a), rd, exp);
    chk($sformatf("pready_drop d%0d", d), {31'b0, pready_w[d]}, 32'h0);
    chk($sformatf("prdata_clear d%0d", d), prdata_w[d], 32'h0);
    if (wr && !e) mregs[d][a[5:2]] = wd;
  endtask

  initial begin
    logic [31:0] rd;
    logic        se;
    int          waits;
    int          hit;

    tbl[0]  = '{1, 1'b1, 12'h004, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1, 1'b0, 12'h004, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{0, 1'b1, 12'h000, 32'h11112222, 32'h0,        1'b0};
    tbl[3]  = '{0, 1'b1, 12'h03C, 32'h33334444, 32'h0,        1'b0};
    tbl[4]  = '{0, 1'b0, 12'h000, 32'h0,        32'h11112222, 1'b0};
    tbl[5]  = '{0, 1'b0, 12'h03C, 32'h0,        32'h33334444, 1'b0};
    tbl[6]  = '{1, 1'b0, 12'h040, 32'h0,        32'h0,        1'b1};
    tbl[7]  = '{1, 1'b1, 12'h006, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[8]  = '{1, 1'b0, 12'h004, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[9]  = '{1, 1'b0, 12'h000, 32'h0,        32'h0,        1'b0};
    tbl[10] = '{2, 1'b1, 12'h008, 32'h12340002, 32'h0,        1'b0};
    tbl[11] = '{2, 1'b0, 12'h008, 32'h0,        32'h12340002, 1'b0};

    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 16; i++) mregs[d][i] = 32'h0;

    rstn = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_pready d%0d", d), {31'b0, pready_w[d]}, 32'h0);
      chk($sformatf("rst_pslverr d%0d", d), {31'b0, pslverr_w[d]}, 32'h0);
      chk($sformatf("rst_prdata d%0d", d), prdata_w[d], 32'h0);
    end
    tick(2);
    rstn = 1'b1;
    tick(1);

    // Directed vectors, back-to-back with no idle cycle between entries.
    for (int k = 0; k < 12; k++) begin
      xfer(tbl[k].d, tbl[k].wr, tbl[k].a, tbl[k].wd, rd, se, waits);
      chk($sformatf("tbl%0d waits", k), 32'(waits), 32'(wc[tbl[k].d]));
      chk($sformatf("tbl%0d pslverr", k), {31'b0, se}, {31'b0, tbl[k].ee});
      if (!tbl[k].wr) chk($sformatf("tbl%0d prdata", k), rd, tbl[k].er);
      if (tbl[k].wr && !tbl[k].ee) mregs[tbl[k].d][tbl[k].a[5:2]] = tbl[k].wd;
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 90; n++) begin
      int          d;
      int          r;
      logic [11:0] a;
      d = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r < 7)       a = {4'h0, 4'($urandom_range(0, 15)), 2'b00};
      else if (r == 7) a = {4'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      else             a = {10'($urandom_range(16, 1023)), 2'b00};
      do_op(d, 1'($urandom_range(0, 1)), a, $urandom);
      tick($urandom_range(0, 2));
    end

    // Abort: drop psel while instance 2 is still in its wait states.
    do_op(2, 1'b1, 12'h008, 32'h12340002);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'hAAAA5555;
    tick(1);
    penable = 1'b1;
    tick(1);
    psel = 3'b000; penable = 1'b0;
    hit = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (pready_w[2] === 1'b1) hit++;
    end
    chk("abort_no_pready", 32'(hit), 32'h0);
    do_op(2, 1'b0, 12'h008, 32'h0);

    // Reset while instance 1 is in DONE and instance 2 is in WAIT.
    do_op(1, 1'b1, 12'h008, 32'hCAFEF00D);
    psel = 3'b110; penable = 1'b0; pwrite = 1'b0; paddr = 12'h008;
    tick(1);
    penable = 1'b1;
    tick(1);
    chk("pre_rst_pready d1", {31'b0, pready_w[1]}, 32'h1);
    chk("pre_rst_prdata d1", prdata_w[1], 32'hCAFEF00D);
    chk("pre_rst_pready d2", {31'b0, pready_w[2]}, 32'h0);
    rstn = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midrst_pready d%0d", d), {31'b0, pready_w[d]}, 32'h0);
      chk($sformatf("midrst_pslverr d%0d", d), {31'b0, pslverr_w[d]}, 32'h0);
      chk($sformatf("midrst_prdata d%0d", d), prdata_w[d], 32'h0);
    end
    psel = 3'b000; penable = 1'b0;
    tick(2);
    rstn = 1'b1;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 16; i++) mregs[d][i] = 32'h0;
    tick(1);
    xfer(1, 1'b0, 12'h008, 32'h0, rd, se, waits);
    chk("post_rst_read d1", rd, 32'h0);
    xfer(0, 1'b0, 12'h03C, 32'h0, rd, se, waits);
    chk("post_rst_read d0", rd, 32'h0);
    do_op(2, 1'b0, 12'h008, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
